// File: rtl/ddr_wr_packer_pkg.sv
// Shared constants, state encoding and helpers for the DDR write packer.
package ddr_wr_packer_pkg;

    localparam int         PIX_PER_WORD = 4;
    localparam int         PIX_W        = 24;
    localparam int         LANE_W       = 32;
    localparam int         WORD_W       = PIX_PER_WORD * LANE_W;
    localparam logic [7:0] PAD          = 8'h00;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_BURST = 2'd2
    } burst_state_t;

    // One 32-bit lane: pad byte above the 24-bit pixel.
    function automatic logic [LANE_W-1:0] pad_pixel(input logic [PIX_W-1:0] pix);
        return {PAD, pix};
    endfunction

endpackage

// File: rtl/ddr_wr_packer_fifo.sv
// First-word-fall-through FIFO. When empty, dout keeps showing the last
// word that was popped (zero after reset) so a stray pop leaves it unchanged.
module sync_fifo_fwft #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 256,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             sclk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [WIDTH-1:0] last_q;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    // A push into a full FIFO is accepted only when a pop frees a slot this cycle.
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? last_q : mem[rd_ptr];

    // Storage array write port.
    always_ff @(posedge sclk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointer, occupancy and held-output bookkeeping.
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            last_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                last_q <= mem[rd_ptr];
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ddr_wr_packer.sv
// Packs a 24-bit pixel stream four-per-word into a FWFT FIFO and issues
// fixed-length DDR write bursts with frame-linear, wrapping word addresses.
module ddr_wr_packer
    import ddr_wr_packer_pkg::*;
#(
    parameter int BURST_LEN   = 64,
    parameter int FIFO_DEPTH  = 256,
    parameter int ADDR_W      = 24,
    parameter int FRAME_WORDS = 230400
) (
    input  logic              sclk,
    input  logic              rst_n,
    input  logic              pi_sof,
    input  logic              pi_pix_valid,
    input  logic [PIX_W-1:0]  pi_pix_data,
    output logic              wr_start,
    output logic [ADDR_W-1:0] wr_addr,
    input  logic              wr_data_req,
    output logic [WORD_W-1:0] wr_data,
    input  logic              user_wr_end,
    output logic              frame_done,
    output logic              overflow,
    output logic              sync_err
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic              cap_en;
    logic [1:0]        pack_idx;
    logic [WORD_W-1:0] acc_word;
    logic [WORD_W-1:0] push_word;
    logic              push_v;
    logic              accept;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CW-1:0]     fifo_count;
    burst_state_t      state;

    // The sof pixel itself is accepted even before capture has been enabled.
    assign accept   = pi_pix_valid && (cap_en || pi_sof);
    assign fifo_pop = (state == ST_BURST) && wr_data_req && !fifo_empty;

    sync_fifo_fwft #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .sclk  (sclk),
        .rst_n (rst_n),
        .push  (push_v),
        .din   (push_word),
        .pop   (fifo_pop),
        .dout  (wr_data),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Capture enable, lane packing and the registered push toward the FIFO.
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            cap_en    <= 1'b0;
            pack_idx  <= '0;
            acc_word  <= '0;
            push_word <= '0;
            push_v    <= 1'b0;
            sync_err  <= 1'b0;
        end else begin
            push_v <= 1'b0;
            if (accept) begin
                if (pi_sof) begin
                    // A partial word at sof is discarded; the sof pixel restarts lane 0.
                    cap_en <= 1'b1;
                    if (pack_idx != '0) begin
                        sync_err <= 1'b1;
                    end
                    acc_word[WORD_W-1 -: LANE_W] <= pad_pixel(pi_pix_data);
                    pack_idx <= 2'd1;
                end else if (pack_idx == 2'(PIX_PER_WORD - 1)) begin
                    push_word <= {acc_word[WORD_W-1:LANE_W], pad_pixel(pi_pix_data)};
                    push_v    <= 1'b1;
                    pack_idx  <= '0;
                end else begin
                    acc_word[LANE_W*(PIX_PER_WORD-1-int'(pack_idx)) +: LANE_W] <= pad_pixel(pi_pix_data);
                    pack_idx <= pack_idx + 1'b1;
                end
            end
        end
    end

    // Sticky flag for a packed word lost to a full FIFO with no pop alongside it.
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (push_v && fifo_full && !fifo_pop) begin
            overflow <= 1'b1;
        end
    end

    // Burst sequencer with the frame-wrapping address counter.
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            wr_start   <= 1'b0;
            wr_addr    <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (fifo_count >= CW'(BURST_LEN)) begin
                        state    <= ST_REQ;
                        wr_start <= 1'b1;
                    end
                end
                ST_REQ: begin
                    wr_start <= 1'b0;
                    state    <= ST_BURST;
                end
                ST_BURST: begin
                    if (user_wr_end) begin
                        state <= ST_IDLE;
                        if (wr_addr == ADDR_W'(FRAME_WORDS - BURST_LEN)) begin
                            wr_addr    <= '0;
                            frame_done <= 1'b1;
                        end else begin
                            wr_addr <= wr_addr + ADDR_W'(BURST_LEN);
                        end
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    wr_start <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ddr_wr_packer.sv
// Bench for ddr_wr_packer with reduced geometry (4-word bursts, 16-word FIFO,
// 32-word frames) so every behaviour is reached in a few thousand cycles.
module tb_ddr_wr_packer;

    localparam int BL    = 4;
    localparam int DEPTH = 16;
    localparam int AW    = 24;
    localparam int FW    = 32;
    localparam int PPW   = 4;

    logic          sclk = 1'b0;
    logic          rst_n = 1'b0;
    logic          pi_sof = 1'b0;
    logic          pi_pix_valid = 1'b0;
    logic [23:0]   pi_pix_data = '0;
    logic          wr_start;
    logic [AW-1:0] wr_addr;
    logic          wr_data_req;
    logic [127:0]  wr_data;
    logic          user_wr_end;
    logic          frame_done;
    logic          overflow;
    logic          sync_err;

    logic ctrl_req = 1'b0, man_req = 1'b0;
    logic ctrl_end = 1'b0, man_end = 1'b0;
    assign wr_data_req = ctrl_req | man_req;
    assign user_wr_end = ctrl_end | man_end;

    ddr_wr_packer #(
        .BURST_LEN   (BL),
        .FIFO_DEPTH  (DEPTH),
        .ADDR_W      (AW),
        .FRAME_WORDS (FW)
    ) dut (
        .sclk         (sclk),
        .rst_n        (rst_n),
        .pi_sof       (pi_sof),
        .pi_pix_valid (pi_pix_valid),
        .pi_pix_data  (pi_pix_data),
        .wr_start     (wr_start),
        .wr_addr      (wr_addr),
        .wr_data_req  (wr_data_req),
        .wr_data      (wr_data),
        .user_wr_end  (user_wr_end),
        .frame_done   (frame_done),
        .overflow     (overflow),
        .sync_err     (sync_err)
    );

    always #5 sclk = ~sclk;

    int checks = 0;
    int failures = 0;

    // Reference model state: expected words in order, partial pixels, flags.
    logic [127:0] exp_q[$];
    logic [23:0]  m_part[$];
    bit           m_cap = 0;
    bit           m_sync = 0;
    int           exp_addr = 0;
    int           bursts = 0;
    int           start_cnt = 0;
    bit           ctrl_en = 0;
    bit           ctrl_gaps = 0;
    bit           ctrl_busy = 0;

    typedef struct {
        logic [23:0]  pix [4];
        logic [127:0] exp;
    } vec_t;
    vec_t tbl [4];

    task automatic chk(string name, logic [127:0] act, logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic [127:0] pack4(logic [23:0] a, logic [23:0] b, logic [23:0] c, logic [23:0] d);
        return {8'h00, a, 8'h00, b, 8'h00, c, 8'h00, d};
    endfunction

    task automatic model_pix(logic [23:0] d, bit sof);
        if (sof) begin
            if (m_part.size() != 0) m_sync = 1;
            m_part.delete();
            m_part.push_back(d);
            m_cap = 1;
        end else if (m_cap) begin
            m_part.push_back(d);
        end
        if (m_part.size() == PPW) begin
            exp_q.push_back(pack4(m_part[0], m_part[1], m_part[2], m_part[3]));
            m_part.delete();
        end
    endtask

    task automatic send_pix(logic [23:0] d, bit sof);
        pi_pix_valid = 1'b1;
        pi_pix_data  = d;
        pi_sof       = sof;
        @(posedge sclk); #1;
        pi_pix_valid = 1'b0;
        pi_sof       = 1'b0;
    endtask

    task automatic drive(logic [23:0] d, bit sof);
        model_pix(d, sof);
        send_pix(d, sof);
    endtask

    task automatic idle(int n);
        repeat (n) begin @(posedge sclk); #1; end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        pi_pix_valid = 1'b0;
        pi_sof = 1'b0;
        man_req = 1'b0;
        man_end = 1'b0;
        idle(3);
        exp_q.delete();
        m_part.delete();
        m_cap = 0;
        m_sync = 0;
        exp_addr = 0;
        rst_n = 1'b1;
        idle(1);
    endtask

    task automatic drain(string name);
        int n = 0;
        while ((exp_q.size() != 0 || ctrl_busy) && n < 3000) begin
            @(negedge sclk);
            n++;
        end
        chk(name, (exp_q.size() == 0 && !ctrl_busy), 1'b1);
        idle(4);
    endtask

    task automatic man_pop(string name, logic [127:0] req);
        man_req = 1'b1;
        @(negedge sclk);
        chk(name, wr_data, req);
        @(posedge sclk); #1;
        man_req = 1'b0;
    endtask

    always @(negedge sclk) begin
        if (rst_n && wr_start) start_cnt++;
    end

    // Responsive DDR controller model used whenever ctrl_en is set.
    initial begin
        logic [AW-1:0] a;
        forever begin
            @(negedge sclk);
            if (ctrl_en && rst_n && wr_start) begin
                ctrl_busy = 1;
                a = wr_addr;
                chk("burst_addr", a, exp_addr);
                @(posedge sclk); #1;
                for (int i = 0; i < BL; i++) begin
                    if (ctrl_gaps) begin
                        repeat ($urandom_range(0, 1)) begin @(posedge sclk); #1; end
                    end
                    ctrl_req = 1'b1;
                    @(negedge sclk);
                    if (exp_q.size() == 0) chk("burst_word_unexpected", wr_data, '0 - 1);
                    else chk("burst_word", wr_data, exp_q.pop_front());
                    chk("addr_stable", wr_addr, a);
                    @(posedge sclk); #1;
                    ctrl_req = 1'b0;
                end
                ctrl_end = 1'b1;
                @(posedge sclk); #1;
                ctrl_end = 1'b0;
                @(negedge sclk);
                chk("frame_done", frame_done, (int'(a) == FW - BL));
                exp_addr = (int'(a) + BL == FW) ? 0 : int'(a) + BL;
                bursts++;
                ctrl_busy = 0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, b0;
        logic [127:0] last_w;

        tbl[0].pix = '{24'h000000, 24'h000001, 24'h000002, 24'h000003};
        tbl[0].exp = 128'h00000000_00000001_00000002_00000003;
        tbl[1].pix = '{24'hFFFFFF, 24'h000000, 24'hFFFFFF, 24'h000000};
        tbl[1].exp = 128'h00FFFFFF_00000000_00FFFFFF_00000000;
        tbl[2].pix = '{24'h123456, 24'hABCDEF, 24'h00FF00, 24'h800001};
        tbl[2].exp = 128'h00123456_00ABCDEF_0000FF00_00800001;
        tbl[3].pix = '{24'hA5A5A5, 24'h5A5A5A, 24'h010203, 24'hFEDCBA};
        tbl[3].exp = 128'h00A5A5A5_005A5A5A_00010203_00FEDCBA;

        // Reset values.
        do_reset();
        @(negedge sclk);
        chk("rst_wr_start", wr_start, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_sync_err", sync_err, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_fifo_count", dut.fifo_count, 0);

        // Pixels before any sof are ignored.
        s0 = start_cnt;
        for (int i = 0; i < 24; i++) drive(24'(i + 100), 0);
        idle(6);
        chk("presof_fifo_count", dut.fifo_count, 0);
        chk("presof_no_start", start_cnt - s0, 0);

        // Table-driven packing: one burst at address 0.
        ctrl_en = 1;
        s0 = start_cnt;
        b0 = bursts;
        for (int e = 0; e < 4; e++) exp_q.push_back(tbl[e].exp);
        for (int e = 0; e < 4; e++)
            for (int k = 0; k < 4; k++) send_pix(tbl[e].pix[k], (e == 0 && k == 0));
        drain("tbl_drain");
        chk("tbl_one_start", start_cnt - s0, 1);
        chk("tbl_one_burst", bursts - b0, 1);

        // Two frames plus one burst of random pixels with random gaps on both sides.
        do_reset();
        ctrl_gaps = 1;
        b0 = bursts;
        for (int f = 0; f < 3; f++) begin
            for (int p = 0; p < ((f < 2) ? FW * PPW : BL * PPW); p++) begin
                if ($urandom_range(0, 3) == 0) idle(1);
                drive(24'($urandom), (p == 0 && f < 2) || (f == 2 && p == 0 && 0));
            end
        end
        drain("frame_drain");
        chk("frame_bursts", bursts - b0, 2 * (FW / BL) + 1);
        chk("frame_next_addr", exp_addr, BL);
        chk("frame_overflow", overflow, 0);
        chk("frame_sync_err", sync_err, 0);
        ctrl_gaps = 0;

        // sof after two pixels: partial word discarded, sof pixel leads next word.
        do_reset();
        drive(24'h111111, 1);
        drive(24'h222222, 0);
        idle(2);
        chk("sync_err_pre", sync_err, 0);
        drive(24'h333333, 1);
        for (int i = 0; i < BL * PPW - 1; i++) drive(24'(24'h400000 + i), 0);
        idle(2);
        chk("sync_err_set", sync_err, m_sync);
        chk("sync_first_word_head", exp_q[0][119:96], 24'h333333);
        drain("sync_drain");

        // Stalled controller: FIFO fills, later words dropped, stored words intact.
        ctrl_en = 0;
        do_reset();
        s0 = start_cnt;
        for (int i = 0; i < DEPTH * PPW; i++) send_pix(24'(i), i == 0);
        idle(3);
        chk("ovf_not_yet", overflow, 0);
        chk("ovf_full_count", dut.fifo_count, DEPTH);
        for (int i = DEPTH * PPW; i < (DEPTH + 1) * PPW; i++) send_pix(24'(i), 0);
        idle(3);
        chk("ovf_set", overflow, 1);
        for (int i = (DEPTH + 1) * PPW; i < (DEPTH + 12) * PPW; i++) send_pix(24'(i), 0);
        idle(3);
        chk("ovf_count_held", dut.fifo_count, DEPTH);
        chk("ovf_one_start", start_cnt - s0, 1);
        for (int w = 0; w < DEPTH; w++)
            man_pop("ovf_readback", pack4(24'(4*w), 24'(4*w+1), 24'(4*w+2), 24'(4*w+3)));
        last_w = pack4(24'(4*DEPTH-4), 24'(4*DEPTH-3), 24'(4*DEPTH-2), 24'(4*DEPTH-1));
        chk("ovf_empty", dut.fifo_count, 0);
        man_req = 1'b1;
        @(posedge sclk); #1;
        man_req = 1'b0;
        @(negedge sclk);
        chk("empty_pop_hold", wr_data, last_w);
        chk("empty_pop_count", dut.fifo_count, 0);
        man_end = 1'b1;
        @(posedge sclk); #1;
        man_end = 1'b0;
        idle(3);
        chk("ovf_addr_adv", wr_addr, BL);

        // Reset in the middle of a burst.
        do_reset();
        s0 = start_cnt;
        for (int i = 0; i < BL * PPW; i++) send_pix(24'(i + 24'h500), i == 0);
        idle(4);
        chk("midrst_start", start_cnt - s0, 1);
        man_pop("midrst_pop0", pack4(24'h500, 24'h501, 24'h502, 24'h503));
        man_req = 1'b1;
        @(negedge sclk);
        rst_n = 1'b0;
        #1;
        chk("midrst_wr_start", wr_start, 0);
        chk("midrst_count", dut.fifo_count, 0);
        chk("midrst_addr", wr_addr, 0);
        chk("midrst_wr_data", wr_data, 0);
        @(posedge sclk); #1;
        man_req = 1'b0;
        idle(2);
        rst_n = 1'b1;
        exp_q.delete(); m_part.delete(); m_cap = 0; m_sync = 0; exp_addr = 0;
        idle(1);
        for (int i = 0; i < 16; i++) drive(24'(i + 24'h600), 0);
        idle(4);
        chk("midrst_nocap", dut.fifo_count, 0);
        ctrl_en = 1;
        b0 = bursts;
        for (int i = 0; i < BL * PPW; i++) drive(24'($urandom), i == 0);
        drain("midrst_drain");
        chk("midrst_burst", bursts - b0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
